// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small circular TX FIFO.
// Snoops cpu store traffic; TXDATA at BASE+0 queues a byte, STATUS at BASE+4
// reads back FIFO/FSM state and clears the sticky overflow flag on store.
`timescale 1ns/1ps

module uart_tx_mmio #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_wr_sig,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   output logic        hit,
   output logic [31:0] rd_data,
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;

   logic [1:0]    state_reg, state_next;
   logic [15:0]   bit_cnt_reg, bit_cnt_next;
   logic [2:0]    bit_idx_reg, bit_idx_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;

   logic          sel_data, sel_status;
   logic          fifo_full, fifo_empty;
   logic          push, pop;
   logic          busy;
   logic [31:0]   count_wide;
   logic [2:0]    count_sat;
   logic          unused_bits;

   assign sel_data    = (mem_addr == BASE_ADDR);
   assign sel_status  = (mem_addr == (BASE_ADDR + 32'd4));
   assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
   assign fifo_empty  = (count_reg == '0);
   // Full is judged on pre-edge state, so a push racing a pop on a full FIFO is dropped.
   assign push        = mem_wr_sig & sel_data & ~fifo_full;
   assign busy        = (state_reg != ST_IDLE);
   assign unused_bits = ^mem_wr_data[31:8];

   // Status word decode; occupancy is saturated to fit the 3-bit field.
   always_comb begin
      count_wide = 32'(count_reg);
      count_sat  = (count_wide > 32'd7) ? 3'd7 : count_wide[2:0];
      hit        = sel_data | sel_status;
      rd_data    = 32'd0;
      if (sel_status)
         rd_data = {25'd0, count_sat, overflow_reg, busy, fifo_empty, fifo_full};
   end

   // Transmit FSM next-state logic; the head byte is popped straight into the shift register.
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      pop          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop          = 1'b1;
               shift_next   = fifo_mem[rd_ptr_reg];
               state_next   = ST_START;
               bit_cnt_next = BIT_LAST;
            end
         end
         ST_START: begin
            if (bit_cnt_reg == 16'd0) begin
               state_next   = ST_DATA;
               bit_cnt_next = BIT_LAST;
               bit_idx_next = 3'd0;
            end else begin
               bit_cnt_next = bit_cnt_reg - 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_cnt_reg == 16'd0) begin
               shift_next   = {1'b0, shift_reg[7:1]};
               bit_cnt_next = BIT_LAST;
               if (bit_idx_reg == 3'd7)
                  state_next = ST_STOP;
               else
                  bit_idx_next = bit_idx_reg + 3'd1;
            end else begin
               bit_cnt_next = bit_cnt_reg - 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_cnt_reg == 16'd0) begin
               if (!fifo_empty) begin
                  // Chain straight into the next frame with no idle gap.
                  pop          = 1'b1;
                  shift_next   = fifo_mem[rd_ptr_reg];
                  state_next   = ST_START;
                  bit_cnt_next = BIT_LAST;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               bit_cnt_next = bit_cnt_reg - 16'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Line level is derived from the next state so tx can be registered without lag.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = shift_next[0];
         default:  tx_next = 1'b1;
      endcase
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= mem_wr_data[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= AW'(wr_ptr_reg + 1'b1);
         if (pop)
            rd_ptr_reg <= AW'(rd_ptr_reg + 1'b1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         if (mem_wr_sig && sel_data && fifo_full)
            overflow_reg <= 1'b1;
         else if (mem_wr_sig && sel_status)
            overflow_reg <= 1'b0;
      end
   end

   // Transmit FSM state, bit timing and serial output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= 16'd0;
         bit_idx_reg <= 3'd0;
         shift_reg   <= 8'd0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
      end
   end

   assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
`timescale 1ns/1ps

module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_wr_sig;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic        hit;
   logic [31:0] rd_data;
   logic        tx;

   int checks   = 0;
   int failures = 0;

   uart_tx_mmio #(
      .CLKS_PER_BIT (4),
      .BASE_ADDR    (BASE),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mem_wr_sig  (mem_wr_sig),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .hit         (hit),
      .rd_data     (rd_data),
      .tx          (tx)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One store captured at the next rising edge; returns 1ns after that edge.
   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_wr_sig  = 1'b1;
      mem_addr    = a;
      mem_wr_data = d;
      @(posedge clk);
      #1;
      mem_wr_sig  = 1'b0;
      $display("store addr=%h data=%h", a, d);
   endtask

   task automatic read_status(input string tag, input logic [31:0] exp);
      mem_addr = BASE + 32'd4;
      #1;
      check_val({tag, "_hit"}, {31'd0, hit}, 32'd1);
      check_val(tag, rd_data, exp);
      $display("status read %s = %h", tag, rd_data);
   endtask

   // Checks one full 10-bit frame, one sample per cycle starting at the next edge.
   task automatic check_frame(input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         check_val("tx_frame", {31'd0, tx}, {31'd0, bits[i/4]});
      end
      $display("frame %h checked", b);
   endtask

   task automatic check_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         check_val("tx_idle", {31'd0, tx}, 32'd1);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      mem_wr_sig  = 1'b0;
      mem_addr    = BASE + 32'd4;
      mem_wr_data = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      check_val("reset_status", rd_data, 32'h0000_0002);
      check_val("reset_hit", {31'd0, hit}, 32'd1);
      check_val("reset_tx", {31'd0, tx}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;

      // Single byte
      do_store(BASE, 32'hFFFF_FF55);
      check_frame(8'h55);
      check_idle(8);
      read_status("status_single", 32'h0000_0002);

      // Back-to-back stores overflowing the FIFO, then overflow clear mid-stream
      do_store(BASE, 32'h01);
      fork
         begin
            for (int v = 2; v <= 6; v++)
               do_store(BASE, 32'(v));
            read_status("status_full", 32'h0000_004D);
            do_store(BASE + 32'd4, 32'h0000_1234);
            read_status("status_ovf_clr", 32'h0000_0045);
         end
         begin
            for (int b = 1; b <= 5; b++)
               check_frame(8'(b));
         end
      join
      check_idle(4);
      read_status("status_drained", 32'h0000_0002);

      // Address decode
      @(negedge clk);
      mem_wr_sig  = 1'b1;
      mem_addr    = BASE + 32'd8;
      mem_wr_data = 32'h77;
      #1;
      check_val("dec_plus8_hit", {31'd0, hit}, 32'd0);
      check_val("dec_plus8_rd", rd_data, 32'd0);
      @(negedge clk);
      mem_addr = BASE - 32'd4;
      #1;
      check_val("dec_minus4_hit", {31'd0, hit}, 32'd0);
      check_val("dec_minus4_rd", rd_data, 32'd0);
      @(negedge clk);
      mem_wr_sig = 1'b0;
      mem_addr   = BASE;
      #1;
      check_val("dec_txdata_hit", {31'd0, hit}, 32'd1);
      check_val("dec_txdata_rd", rd_data, 32'd0);
      read_status("status_decode", 32'h0000_0002);
      check_idle(10);

      // Reset during DATA bit 3 of 0xA3, with 0x5A queued behind it
      do_store(BASE, 32'hA3);
      do_store(BASE, 32'h5A);
      repeat (17) @(posedge clk);
      #2;
      check_val("tx_bit3", {31'd0, tx}, 32'd0);
      #1;
      reset_n = 1'b0;
      #1;
      check_val("tx_async_reset", {31'd0, tx}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      read_status("status_after_reset", 32'h0000_0002);
      check_idle(60);

      // Simultaneous push and pop on the STOP last cycle with two queued
      do_store(BASE, 32'h3C);
      fork
         begin
            do_store(BASE, 32'hC5);
            do_store(BASE, 32'h96);
            repeat (38) @(posedge clk);
            read_status("status_pre_simul", 32'h0000_0024);
            do_store(BASE, 32'h0F);
            read_status("status_simul", 32'h0000_0024);
         end
         begin
            check_frame(8'h3C);
            check_frame(8'hC5);
            check_frame(8'h96);
            check_frame(8'h0F);
         end
      join
      check_idle(4);
      read_status("status_end", 32'h0000_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
